// File: rtl/vga_pkg.sv
// Shared constants, request type and FSM encoding for the VGA pixel sink.
// Coordinates are packed {x[7:0], y[6:0]}; the frame buffer is 160x120, linear y*160+x.
package vga_pkg;

    localparam int          SCREEN_W           = 160;
    localparam int          SCREEN_H           = 120;
    localparam int          FB_WORDS           = 19200;
    localparam logic [8:0]  TRANSPARENT_COLOUR = 9'h1FF;
    localparam int          COORD_X_MSB        = 14;
    localparam int          COORD_Y_MSB        = 6;

    typedef struct packed {
        logic [14:0] addr;
        logic [8:0]  colour;
    } pixel_req_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLEAR = 2'd2
    } sink_state_e;

    // y*160 + x built from shifts so no multiplier is inferred.
    function automatic logic [14:0] fb_addr(input logic [7:0] x, input logic [6:0] y);
        logic [14:0] yw;
        yw = {8'd0, y};
        return (yw << 7) + (yw << 5) + {7'd0, x};
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO, head visible on pop_dat_o with no read latency.
// A push while full is accepted only when a pop happens in the same cycle.
module pixel_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int           AW       = $clog2(DEPTH);
    localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o    = (cnt_q == FULL_CNT);
    assign empty_o   = (cnt_q == '0);
    assign pop_dat_o = mem_q[rd_q];
    assign do_pop    = pop_i && !empty_o;
    assign do_push   = push_i && (!full_o || do_pop);

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_dat_i;
    end

endmodule

// File: rtl/vga_pixel_sink.sv
// Filters and buffers pixel writes, commits them to the frame buffer with valid/ready, plus a clear sweep.
// First write one edge after push; outputs hold under fb_ready=0. Counters via VGA_PIXEL_SINK_STATS_EN.
module vga_pixel_sink #(
    parameter int FIFO_DEPTH       = 16,
    parameter int SCREEN_W         = 160,
    parameter int SCREEN_H         = 120,
    parameter bit SKIP_TRANSPARENT = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [8:0]  colour,
    input  logic [14:0] coordinates,
    input  logic        VGA_write_enable,
    input  logic        clear_req,
    input  logic [8:0]  clear_colour,
    output logic [14:0] fb_address,
    output logic [8:0]  fb_data,
    output logic        fb_wren,
    input  logic        fb_ready,
    output logic        fifo_full,
    output logic        overflow,
    input  logic        clear_overflow,
    output logic        busy
`ifdef VGA_PIXEL_SINK_STATS_EN
    ,
    output logic [15:0] pix_written,
    output logic [15:0] pix_dropped
`endif
);
    import vga_pkg::*;

    localparam logic [14:0] LAST_ADDR = 15'(FB_WORDS - 1);

    logic [7:0]  x;
    logic [6:0]  y;
    logic        req_vld, drop, pop, fifo_empty;
    pixel_req_t  push_dat, head;

    sink_state_e state_q, state_d;
    logic [14:0] addr_q, addr_d;
    logic [8:0]  data_q, data_d, clr_col_q, clr_col_d;
    logic        wren_q, wren_d, pend_q, pend_d, ovf_q;

    assign x = coordinates[COORD_X_MSB:COORD_Y_MSB+1];
    assign y = coordinates[COORD_Y_MSB:0];

    assign req_vld = VGA_write_enable && (x < 8'(SCREEN_W)) && (y < 7'(SCREEN_H))
                     && !(SKIP_TRANSPARENT && (colour == TRANSPARENT_COLOUR));
    assign drop    = req_vld && fifo_full && !pop;

    assign push_dat.addr   = fb_addr(x, y);
    assign push_dat.colour = colour;

    pixel_fifo #(
        .WIDTH ($bits(pixel_req_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push_i     (req_vld),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .pop_dat_o  (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wren_d    = wren_q;
        pend_d    = pend_q;
        clr_col_d = clr_col_q;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    state_d = ST_CLEAR;
                    addr_d  = '0;
                    data_d  = clr_col_q;
                    wren_d  = 1'b1;
                    pend_d  = 1'b0;
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    addr_d  = head.addr;
                    data_d  = head.colour;
                    wren_d  = 1'b1;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (fb_ready) begin
                    if (!pend_q && !fifo_empty) begin
                        pop    = 1'b1;
                        addr_d = head.addr;
                        data_d = head.colour;
                    end else begin
                        wren_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_CLEAR: begin
                // A clear arriving mid-sweep restarts it with the newly latched colour.
                if (pend_q) begin
                    addr_d = '0;
                    data_d = clr_col_q;
                    pend_d = 1'b0;
                end else if (fb_ready) begin
                    if (addr_q == LAST_ADDR) begin
                        wren_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        addr_d = addr_q + 15'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                wren_d  = 1'b0;
            end
        endcase
        if (clear_req) begin
            pend_d    = 1'b1;
            clr_col_d = clear_colour;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            wren_q    <= 1'b0;
            pend_q    <= 1'b0;
            clr_col_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wren_q    <= wren_d;
            pend_q    <= pend_d;
            clr_col_q <= clr_col_d;
            if (drop)                ovf_q <= 1'b1;
            else if (clear_overflow) ovf_q <= 1'b0;
        end
    end

    assign fb_address = addr_q;
    assign fb_data    = data_q;
    assign fb_wren    = wren_q;
    assign overflow   = ovf_q;
    assign busy       = !fifo_empty || (state_q == ST_CLEAR) || wren_q;

`ifdef VGA_PIXEL_SINK_STATS_EN
    logic [15:0] wr_cnt_q, drop_cnt_q;
    logic        wr_evt, drop_evt;

    assign wr_evt   = (state_q == ST_WRITE) && wren_q && fb_ready;
    assign drop_evt = drop || (VGA_write_enable && !req_vld);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else if (clear_overflow) begin
            wr_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (wr_evt && (wr_cnt_q != 16'hFFFF))     wr_cnt_q   <= wr_cnt_q + 16'd1;
            if (drop_evt && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign pix_written = wr_cnt_q;
    assign pix_dropped = drop_cnt_q;
`endif

endmodule

// File: tb/tb_vga_pixel_sink.sv
// Directed bench for vga_pixel_sink: single write, backpressure, overflow, filter, clear sweep, reset mid-clear.
module tb_vga_pixel_sink;

    logic        clk = 1'b0;
    logic        resetn;
    logic [8:0]  colour;
    logic [14:0] coordinates;
    logic        VGA_write_enable;
    logic        clear_req;
    logic [8:0]  clear_colour;
    logic [14:0] fb_address;
    logic [8:0]  fb_data;
    logic        fb_wren;
    logic        fb_ready;
    logic        fifo_full;
    logic        overflow;
    logic        clear_overflow;
    logic        busy;
`ifdef VGA_PIXEL_SINK_STATS_EN
    logic [15:0] pix_written;
    logic [15:0] pix_dropped;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int log_addr[$];
    int log_data[$];

    vga_pixel_sink dut (
        .clk              (clk),
        .resetn           (resetn),
        .colour           (colour),
        .coordinates      (coordinates),
        .VGA_write_enable (VGA_write_enable),
        .clear_req        (clear_req),
        .clear_colour     (clear_colour),
        .fb_address       (fb_address),
        .fb_data          (fb_data),
        .fb_wren          (fb_wren),
        .fb_ready         (fb_ready),
        .fifo_full        (fifo_full),
        .overflow         (overflow),
        .clear_overflow   (clear_overflow),
        .busy             (busy)
`ifdef VGA_PIXEL_SINK_STATS_EN
        ,
        .pix_written      (pix_written),
        .pix_dropped      (pix_dropped)
`endif
    );

    always #10 clk = ~clk;

    // Records every write the frame buffer will accept on the following rising edge.
    always @(negedge clk) begin
        #2;
        if (resetn && fb_wren && fb_ready) begin
            log_addr.push_back(int'(fb_address));
            log_data.push_back(int'(fb_data));
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [8:0] c, input logic [7:0] x, input logic [6:0] y);
        colour           = c;
        coordinates      = {x, y};
        VGA_write_enable = 1'b1;
    endtask

    task automatic wait_idle(input int max_cycles, input string tag);
        int n = 0;
        while (busy && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        int errs;
        bit found;
        resetn = 1'b0; colour = '0; coordinates = '0; VGA_write_enable = 1'b0;
        clear_req = 1'b0; clear_colour = '0; fb_ready = 1'b0; clear_overflow = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_addr", fb_address, 0);
        check("rst_data", fb_data, 0);
        check("rst_flags", {fb_wren, fifo_full, overflow, busy}, 4'b0000);
        resetn = 1'b1;
        @(negedge clk);

        // Single write, x=5 y=2 -> 325
        fb_ready = 1'b1;
        log_addr.delete(); log_data.delete();
        drive(9'h0A3, 8'd5, 7'd2);
        @(negedge clk);
        VGA_write_enable = 1'b0;
        check("single_wren_early", fb_wren, 1'b0);
        @(negedge clk);
        check("single_wren", fb_wren, 1'b1);
        check("single_addr", fb_address, 325);
        check("single_data", fb_data, 9'h0A3);
        @(negedge clk);
        check("single_wren_drop", fb_wren, 1'b0);
        check("single_count", log_addr.size(), 1);

        // Backpressure: three writes held behind fb_ready=0
        fb_ready = 1'b0;
        log_addr.delete(); log_data.delete();
        drive(9'h011, 8'd10, 7'd1);  @(negedge clk);
        drive(9'h022, 8'd20, 7'd3);  @(negedge clk);
        drive(9'h033, 8'd159, 7'd0); @(negedge clk);
        VGA_write_enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("bp_hold", {fb_wren, fb_data, fb_address}, {1'b1, 9'h011, 15'd170});
            @(negedge clk);
        end
        fb_ready = 1'b1;
        @(negedge clk);
        check("bp_second", {fb_wren, fb_data, fb_address}, {1'b1, 9'h022, 15'd500});
        @(negedge clk);
        check("bp_third", {fb_wren, fb_data, fb_address}, {1'b1, 9'h033, 15'd159});
        @(negedge clk);
        check("bp_done", fb_wren, 1'b0);
        check("bp_count", log_addr.size(), 3);
        if (log_addr.size() == 3)
            check("bp_order", {log_addr[0], log_addr[1], log_addr[2]}, {32'd170, 32'd500, 32'd159});

        // Overflow: 20 writes with fb_ready=0; one entry sits in the output stage, 16 in the FIFO
        fb_ready = 1'b0;
        log_addr.delete(); log_data.delete();
        for (int i = 0; i < 20; i++) begin
            drive(9'(i + 16), 8'(i), 7'd0);
            @(negedge clk);
            if (i == 15) check("ovf_not_full_yet", fifo_full, 1'b0);
            if (i == 16) check("ovf_full", {fifo_full, overflow}, 2'b10);
            if (i == 17) check("ovf_set", overflow, 1'b1);
        end
        VGA_write_enable = 1'b0;
        check("ovf_head_held", {fb_wren, fb_address}, {1'b1, 15'd0});
        fb_ready = 1'b1;
        wait_idle(100, "ovf");
        check("ovf_commit_count", log_addr.size(), 17);
        errs = 0;
        for (int i = 0; i < log_addr.size(); i++)
            if (log_addr[i] != i || log_data[i] != i + 16) errs++;
        check("ovf_commit_order", errs, 0);
        check("ovf_sticky", overflow, 1'b1);
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        check("ovf_cleared", overflow, 1'b0);

        // Filter: out-of-range and transparent requests vanish without overflow
        log_addr.delete(); log_data.delete();
        drive(9'h001, 8'd160, 7'd0);  @(negedge clk);
        drive(9'h002, 8'd0, 7'd120);  @(negedge clk);
        drive(9'h1FF, 8'd1, 7'd1);    @(negedge clk);
        VGA_write_enable = 1'b0;
        repeat (5) @(negedge clk);
        check("filter_no_write", log_addr.size(), 0);
        check("filter_no_ovf", {overflow, busy}, 2'b00);
        drive(9'h012, 8'd159, 7'd119);
        @(negedge clk);
        VGA_write_enable = 1'b0;
        wait_idle(20, "corner");
        check("corner_count", log_addr.size(), 1);
        if (log_addr.size() == 1)
            check("corner_write", {log_addr[0], log_data[0]}, {32'd19199, 32'h012});

        // Clear requested while a write is stalled
        fb_ready = 1'b0;
        log_addr.delete(); log_data.delete();
        drive(9'h055, 8'd3, 7'd4);
        @(negedge clk);
        VGA_write_enable = 1'b0;
        @(negedge clk);
        clear_req = 1'b1;
        clear_colour = 9'h007;
        drive(9'h066, 8'd7, 7'd1);
        @(negedge clk);
        clear_req = 1'b0;
        clear_colour = 9'h1AA;
        VGA_write_enable = 1'b0;
        repeat (3) @(negedge clk);
        check("clr_stall_hold", {fb_wren, fb_data, fb_address}, {1'b1, 9'h055, 15'd643});
        fb_ready = 1'b1;
        repeat (50) @(negedge clk);
        drive(9'h077, 8'd9, 7'd9);
        @(negedge clk);
        VGA_write_enable = 1'b0;
        wait_idle(20500, "clr");
        check("clr_count", log_addr.size(), 19203);
        if (log_addr.size() == 19203) begin
            check("clr_first", {log_addr[0], log_data[0]}, {32'd643, 32'h055});
            errs = 0;
            for (int k = 0; k < 19200; k++)
                if (log_addr[k + 1] != k || log_data[k + 1] != 9'h007) errs++;
            check("clr_sweep", errs, 0);
            check("clr_after_q", {log_addr[19201], log_data[19201]}, {32'd167, 32'h066});
            check("clr_after_r", {log_addr[19202], log_data[19202]}, {32'd1449, 32'h077});
        end

        // Reset while the sweep is at address 500
        clear_colour = 9'h0F0;
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 1000 && !found; n++) begin
            if (fb_wren && fb_address == 15'd500) found = 1'b1;
            else @(negedge clk);
        end
        check("rstclr_reach500", found, 1'b1);
        check("rstclr_data", fb_data, 9'h0F0);
        resetn = 1'b0;
        #1;
        check("rstclr_outputs", {fb_address, fb_data, fb_wren, fifo_full, overflow, busy}, 0);
        log_addr.delete(); log_data.delete();
        @(negedge clk);
        resetn = 1'b1;
        repeat (30) @(negedge clk);
        check("rstclr_no_writes", log_addr.size(), 0);
        check("rstclr_quiet", {fb_wren, busy}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
